// File: rtl/vanilla_pc_hist_pkg.sv
// Shared definitions for the vanilla core PC histogram: operation classes, op count,
// dump word layout and the dump FSM state encoding.
package vanilla_pc_hist_pkg;

  typedef enum logic [4:0] {
    e_op_instr = 5'd0,
    e_op_fp_instr,
    e_op_icache_miss,
    e_op_stall_depend_dram,
    e_op_stall_depend_group,
    e_op_stall_depend_global,
    e_op_stall_depend_idiv,
    e_op_stall_depend_fdiv,
    e_op_stall_depend_remote,
    e_op_stall_depend_local,
    e_op_stall_depend_imul,
    e_op_stall_amo_aq,
    e_op_stall_amo_rl,
    e_op_stall_bypass,
    e_op_stall_lr_aq,
    e_op_stall_fence,
    e_op_stall_remote_req,
    e_op_stall_remote_credit,
    e_op_stall_fdiv_busy,
    e_op_stall_idiv_busy,
    e_op_stall_fcsr,
    e_op_stall_remote_ld,
    e_op_stall_ifetch_wait,
    e_op_stall_remote_flw_wb,
    e_op_bubble_branch_miss,
    e_op_bubble_jalr_miss,
    e_op_bubble_icache_miss,
    e_op_bubble_fp_op,
    e_op_unknown
  } vanilla_pc_hist_op_e;

  localparam int vanilla_pc_hist_num_ops_gp    = 29;
  localparam int vanilla_pc_hist_idx_width_gp  = $clog2(vanilla_pc_hist_num_ops_gp + 1);
  localparam int vanilla_pc_hist_data_width_gp = 32;

  // One streamed dump word; index num_ops is the profiled-cycle count.
  typedef struct packed {
    logic [vanilla_pc_hist_idx_width_gp-1:0]  idx;
    logic [vanilla_pc_hist_data_width_gp-1:0] data;
    logic                                     last;
  } vanilla_pc_hist_dump_s;

  typedef enum logic {
    e_idle,
    e_dump
  } vanilla_pc_hist_state_e;

endpackage

// File: rtl/vanilla_pc_hist_sat_counter.sv
// Saturating event counter with clear and clear-on-read.
// Priority: clear > read-clear with inc (=1) > read-clear (=0) > inc.
module vanilla_pc_hist_sat_counter
  import vanilla_pc_hist_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               inc_i,
  input  logic               clear_i,
  input  logic               read_clear_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q, count_d;

  // A read-clear that coincides with an increment keeps that event for the next read.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (read_clear_i) begin
      count_d = inc_i ? width_p'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vanilla_pc_hist_accumulator.sv
// Per-tile PC/op histogram accumulator with a clear-on-read valid/yumi dump port.
// Optional PC window filter enabled by defining VANILLA_PC_HIST_FILTER_EN.
module vanilla_pc_hist_accumulator
  import vanilla_pc_hist_pkg::*;
#(
  parameter  int pc_width_p      = 32,
  parameter  int num_ops_p       = vanilla_pc_hist_num_ops_gp,
  parameter  int counter_width_p = 32,
  localparam int op_width_lp     = (num_ops_p > 1) ? $clog2(num_ops_p) : 1,
  localparam int idx_width_lp    = $clog2(num_ops_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       en_i,
  input  logic                       ev_v_i,
  input  logic [op_width_lp-1:0]     ev_op_i,
  input  logic [pc_width_p-1:0]      ev_pc_i,
  input  logic [pc_width_p-1:0]      pc_lo_i,
  input  logic [pc_width_p-1:0]      pc_hi_i,
  input  logic                       clear_i,
  input  logic                       dump_req_i,
  output logic                       dump_busy_o,
  output logic                       dump_v_o,
  output logic [idx_width_lp-1:0]    dump_idx_o,
  output logic [counter_width_p-1:0] dump_data_o,
  output logic                       dump_last_o,
  input  logic                       dump_yumi_i
);

  localparam int num_ctrs_lp = num_ops_p + 1;

  vanilla_pc_hist_state_e        state_q;
  logic                          dump_v_q;
  logic [idx_width_lp-1:0]       idx_q;
  logic [counter_width_p-1:0]    data_q;

  logic                          op_valid;
  logic                          ev_qual;
  logic                          cyc_inc;
  logic                          last_word;
  logic                          load_en;
  logic [idx_width_lp-1:0]       load_idx;
  logic [counter_width_p-1:0]    load_data;
  logic [num_ctrs_lp-1:0]        inc_vec;
  logic [num_ctrs_lp-1:0]        rc_vec;
  logic [counter_width_p-1:0]    count [num_ctrs_lp];

  // Compare in the wider index width so a power-of-two op count cannot alias to zero.
  assign op_valid = (idx_width_lp'(ev_op_i) < idx_width_lp'(num_ops_p));

`ifdef VANILLA_PC_HIST_FILTER_EN
  logic in_window;
  assign in_window = (ev_pc_i >= pc_lo_i) && (ev_pc_i <= pc_hi_i);
  assign ev_qual   = en_i & ev_v_i & op_valid & in_window;
  assign cyc_inc   = en_i & ev_v_i & in_window;
`else
  logic unused_pc;
  assign unused_pc = ^{ev_pc_i, pc_lo_i, pc_hi_i};
  assign ev_qual   = en_i & ev_v_i & op_valid;
  assign cyc_inc   = en_i;
`endif

  assign last_word = (idx_q == idx_width_lp'(num_ops_p));

  always_comb begin
    load_en  = 1'b0;
    load_idx = '0;
    if (state_q == e_idle) begin
      load_en = dump_req_i;
    end else if (dump_yumi_i && !last_word) begin
      load_en  = 1'b1;
      load_idx = idx_q + idx_width_lp'(1);
    end
  end

  always_comb begin
    inc_vec = '0;
    rc_vec  = '0;
    for (int k = 0; k < num_ops_p; k++) begin
      inc_vec[k] = ev_qual && (ev_op_i == op_width_lp'(k));
    end
    inc_vec[num_ops_p] = cyc_inc;
    for (int k = 0; k < num_ctrs_lp; k++) begin
      rc_vec[k] = load_en && (load_idx == idx_width_lp'(k));
    end
  end

  always_comb begin
    load_data = '0;
    for (int k = 0; k < num_ctrs_lp; k++) begin
      if (load_idx == idx_width_lp'(k)) begin
        load_data = count[k];
      end
    end
  end

  for (genvar g = 0; g < num_ctrs_lp; g++) begin : g_ctr
    vanilla_pc_hist_sat_counter #(
      .width_p(counter_width_p)
    ) u_ctr (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .inc_i       (inc_vec[g]),
      .clear_i     (clear_i),
      .read_clear_i(rc_vec[g]),
      .count_o     (count[g])
    );
  end

  // Dump FSM and output register; a word holds until the consumer yumis it.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= e_idle;
      dump_v_q <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      case (state_q)
        e_idle: begin
          if (dump_req_i) begin
            state_q  <= e_dump;
            dump_v_q <= 1'b1;
            idx_q    <= load_idx;
            data_q   <= load_data;
          end
        end
        e_dump: begin
          if (dump_yumi_i) begin
            if (last_word) begin
              state_q  <= e_idle;
              dump_v_q <= 1'b0;
            end else begin
              idx_q  <= load_idx;
              data_q <= load_data;
            end
          end
        end
        default: begin
          state_q  <= e_idle;
          dump_v_q <= 1'b0;
        end
      endcase
    end
  end

  assign dump_busy_o = (state_q == e_dump);
  assign dump_v_o    = dump_v_q;
  assign dump_idx_o  = idx_q;
  assign dump_data_o = data_q;
  assign dump_last_o = dump_v_q & last_word;

endmodule

// File: tb/tb_vanilla_pc_hist_accumulator.sv
// Directed bench for vanilla_pc_hist_accumulator: a 32-bit and a 4-bit counter instance
// run in lockstep on shared inputs; optional PC filter expectations follow VANILLA_PC_HIST_FILTER_EN.
module tb_vanilla_pc_hist_accumulator;
  import vanilla_pc_hist_pkg::*;

  localparam int NumOps   = vanilla_pc_hist_num_ops_gp;
  localparam int NumWords = NumOps + 1;

  typedef struct {
    logic        resetN;
    logic        en;
    logic        evV;
    logic [4:0]  evOp;
    logic        clr;
    logic        req;
    logic        yumi;
    logic        expV;
    logic [4:0]  expIdx;
    logic [31:0] expData;
    logic        expLast;
  } vec_t;

  logic        clk;
  logic        resetN, en, evV, clr, dumpReq, dumpYumi;
  logic [4:0]  evOp;
  logic [31:0] evPc, pcLo, pcHi;
  logic        dumpBusy, dumpV, dumpLast;
  logic [4:0]  dumpIdx;
  logic [31:0] dumpData;
  logic        dumpBusy4, dumpV4, dumpLast4;
  logic [4:0]  dumpIdx4;
  logic [3:0]  dumpData4;

  int          checks = 0;
  int          errors = 0;
  int          evSent = 0;
  bit          streamOp1 = 1'b0;
  logic [31:0] expW  [NumWords];
  logic [3:0]  expW4 [NumWords];
  vec_t        vecs  [16];

  vanilla_pc_hist_accumulator #(
    .pc_width_p(32), .num_ops_p(NumOps), .counter_width_p(32)
  ) dut (
    .clk_i(clk), .reset_n_i(resetN), .en_i(en), .ev_v_i(evV), .ev_op_i(evOp),
    .ev_pc_i(evPc), .pc_lo_i(pcLo), .pc_hi_i(pcHi), .clear_i(clr),
    .dump_req_i(dumpReq), .dump_busy_o(dumpBusy), .dump_v_o(dumpV),
    .dump_idx_o(dumpIdx), .dump_data_o(dumpData), .dump_last_o(dumpLast),
    .dump_yumi_i(dumpYumi)
  );

  vanilla_pc_hist_accumulator #(
    .pc_width_p(32), .num_ops_p(NumOps), .counter_width_p(4)
  ) dut4 (
    .clk_i(clk), .reset_n_i(resetN), .en_i(en), .ev_v_i(evV), .ev_op_i(evOp),
    .ev_pc_i(evPc), .pc_lo_i(pcLo), .pc_hi_i(pcHi), .clear_i(clr),
    .dump_req_i(dumpReq), .dump_busy_o(dumpBusy4), .dump_v_o(dumpV4),
    .dump_idx_o(dumpIdx4), .dump_data_o(dumpData4), .dump_last_o(dumpLast4),
    .dump_yumi_i(dumpYumi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog simulation did not finish, required completion before 400000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    if (streamOp1) begin
      en     = 1'b1;
      evV    = 1'b1;
      evOp   = 5'd1;
      evSent++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    resetN   = v.resetN;
    en       = v.en;
    evV      = v.evV;
    evOp     = v.evOp;
    clr      = v.clr;
    dumpReq  = v.req;
    dumpYumi = v.yumi;
  endtask

  function automatic logic [3:0] sat4(input logic [31:0] v);
    return (v > 32'd15) ? 4'hF : v[3:0];
  endfunction

  task automatic clearExp();
    for (int i = 0; i < NumWords; i++) expW[i] = '0;
  endtask

  task automatic finishExp();
    for (int i = 0; i < NumWords; i++) expW4[i] = sat4(expW[i]);
  endtask

  task automatic sendEvents(input logic [4:0] op, input int n, input logic [31:0] pc);
    for (int k = 0; k < n; k++) begin
      en   = 1'b1;
      evV  = 1'b1;
      evOp = op;
      evPc = pc;
      step();
    end
    en  = 1'b0;
    evV = 1'b0;
  endtask

  // Drains a dump from word firstIdx, stalling each word; abortIdx >= 0 resets at that word.
  task automatic runDump(input bit startReq, input int firstIdx, input int stall,
                         input int abortIdx, input string tag);
    int                    idx, waitCnt, budget;
    bit                    done, aborted;
    logic [31:0]           held;
    vanilla_pc_hist_dump_s word;
    if (startReq) begin
      dumpReq = 1'b1;
      step();
      dumpReq = 1'b0;
      clr     = 1'b0;
      if (!streamOp1) begin
        en  = 1'b0;
        evV = 1'b0;
      end
      checkOutput({tag, "_lat_v"}, 32'(dumpV), 32'd1);
    end
    idx = firstIdx; waitCnt = 0; budget = 0; done = 1'b0; aborted = 1'b0; held = '0;
    while (!done) begin
      budget++;
      if (budget > 1000 || !dumpV) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s_stream dump_v=%0b at word %0d after %0d cycles, required 1",
                 tag, dumpV, idx, budget);
        done = 1'b1;
      end else if (idx == abortIdx) begin
        checkOutput({tag, "_abort_idx"}, 32'(dumpIdx), 32'(idx));
        resetN = 1'b0;
        step();
        checkOutput({tag, "_abort_v"}, 32'(dumpV), 32'd0);
        checkOutput({tag, "_abort_v4"}, 32'(dumpV4), 32'd0);
        checkOutput({tag, "_abort_busy"}, 32'(dumpBusy), 32'd0);
        checkOutput({tag, "_abort_last"}, 32'(dumpLast), 32'd0);
        checkOutput({tag, "_abort_idx0"}, 32'(dumpIdx), 32'd0);
        checkOutput({tag, "_abort_data"}, dumpData, 32'd0);
        resetN  = 1'b1;
        aborted = 1'b1;
        done    = 1'b1;
      end else if (waitCnt < stall) begin
        if (waitCnt == 0) held = dumpData;
        else checkOutput($sformatf("%s_w%0d_hold", tag, idx), dumpData, held);
        dumpYumi = 1'b0;
        waitCnt++;
        step();
      end else begin
        if (stall > 0) checkOutput($sformatf("%s_w%0d_hold", tag, idx), dumpData, held);
        word = '{idx: dumpIdx, data: dumpData, last: dumpLast};
        checkOutput($sformatf("%s_w%0d_idx", tag, idx), 32'(word.idx), 32'(idx));
        checkOutput($sformatf("%s_w%0d_data", tag, idx), word.data, expW[idx]);
        checkOutput($sformatf("%s_w%0d_last", tag, idx), 32'(word.last), 32'(idx == NumOps));
        checkOutput($sformatf("%s_w%0d_idx4", tag, idx), 32'(dumpIdx4), 32'(idx));
        checkOutput($sformatf("%s_w%0d_data4", tag, idx), 32'(dumpData4), 32'(expW4[idx]));
        checkOutput($sformatf("%s_w%0d_last4", tag, idx), 32'(dumpLast4), 32'(idx == NumOps));
        dumpYumi = 1'b1;
        step();
        dumpYumi = 1'b0;
        waitCnt  = 0;
        if (idx == NumOps) done = 1'b1;
        else idx++;
      end
    end
    if (!aborted) begin
      checkOutput({tag, "_end_v"}, 32'(dumpV), 32'd0);
      checkOutput({tag, "_end_busy"}, 32'(dumpBusy), 32'd0);
      checkOutput({tag, "_end_busy4"}, 32'(dumpBusy4), 32'd0);
    end
  endtask

  initial begin
    resetN = 1'b0; en = 1'b0; evV = 1'b0; evOp = '0; clr = 1'b0;
    dumpReq = 1'b0; dumpYumi = 1'b0;
    evPc = '0; pcLo = '0; pcHi = '1;

    //           rst   en    evV   op     clr   req   yumi  v     idx    data   last
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'd0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'd0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'd0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'd5, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd5, 1'b0};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d_v", i), 32'(dumpV), 32'(vecs[i].expV));
      checkOutput($sformatf("vec%0d_busy", i), 32'(dumpBusy), 32'(vecs[i].expV));
      checkOutput($sformatf("vec%0d_idx", i), 32'(dumpIdx), 32'(vecs[i].expIdx));
      checkOutput($sformatf("vec%0d_data", i), dumpData, vecs[i].expData);
      checkOutput($sformatf("vec%0d_data4", i), 32'(dumpData4), vecs[i].expData);
      checkOutput($sformatf("vec%0d_last", i), 32'(dumpLast), 32'(vecs[i].expLast));
    end

    clearExp(); expW[3] = 32'd5; expW[29] = 32'd8; finishExp();
    runDump(1'b0, 3, 0, -1, "A");

    clearExp(); expW[0] = 32'd20; expW[29] = 32'd20; finishExp();
    sendEvents(5'd0, 20, 32'd0);
    runDump(1'b1, 0, 0, -1, "B");

    clearExp(); expW[1] = 32'd4; expW[29] = 32'd116; finishExp();
    evSent    = 0;
    streamOp1 = 1'b1;
    runDump(1'b1, 0, 3, -1, "C1");
    streamOp1 = 1'b0;
    en = 1'b0; evV = 1'b0;
    clearExp(); expW[1] = 32'(evSent - 4); expW[29] = 32'(evSent - 116); finishExp();
    runDump(1'b1, 0, 0, -1, "C2");

    clearExp(); expW[0] = 32'd2; expW[29] = 32'd3; finishExp();
    sendEvents(5'd0, 2, 32'd0);
    en = 1'b1; evV = 1'b1; evOp = 5'd0;
    runDump(1'b1, 0, 0, -1, "D1");
    clearExp(); expW[0] = 32'd1; finishExp();
    runDump(1'b1, 0, 0, -1, "D1b");

    clearExp(); expW[0] = 32'd2; finishExp();
    sendEvents(5'd0, 2, 32'd0);
    en = 1'b1; evV = 1'b1; evOp = 5'd0; clr = 1'b1;
    runDump(1'b1, 0, 0, -1, "D2");
    clearExp(); finishExp();
    runDump(1'b1, 0, 0, -1, "D2b");

    clearExp(); expW[5] = 32'd3; finishExp();
    sendEvents(5'd5, 3, 32'd0);
    runDump(1'b1, 0, 0, 10, "E1");
    sendEvents(5'd31, 4, 32'd0);
    clearExp(); expW[29] = 32'd4; finishExp();
    runDump(1'b1, 0, 0, -1, "E2");

    pcLo = 32'h100; pcHi = 32'h1FC;
    sendEvents(5'd7, 1, 32'h0FC);
    sendEvents(5'd7, 1, 32'h100);
    sendEvents(5'd7, 1, 32'h1FC);
    sendEvents(5'd7, 1, 32'h200);
    pcLo = 32'h200; pcHi = 32'h100;
    sendEvents(5'd8, 2, 32'h180);
    pcLo = '0; pcHi = '1;
    clearExp();
`ifdef VANILLA_PC_HIST_FILTER_EN
    expW[7] = 32'd2; expW[8] = 32'd0; expW[29] = 32'd2;
`else
    expW[7] = 32'd4; expW[8] = 32'd2; expW[29] = 32'd6;
`endif
    finishExp();
    runDump(1'b1, 0, 0, -1, "F");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
